spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
- Synchronous SPI bus master (mode 0: CPOL=0, CPHA=0) that turns single register read/write commands into SPI frames toward DSD1792A-style register slaves.
- Sits directly upstream of the converter SPI slaves: it drives sck/ss/mosi and samples miso.
- Frame layout is MSB first: R/W bit (1 = read), then the address bits, then the data bits. Read data is returned on a one-cycle response strobe.

Parameters:
- MAX_ADDR_BITS, 16, largest supported address field, including the R/W bit.
- MAX_DATA_BITS, 16, largest supported data field.
- CLK_DIV, 4, clk cycles per sck half-period (≥1).
- SS_GAP, 4, minimum clk cycles ss stays high between frames (≥2, so the slave's ss edge detector sees every rise).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_read  in  1  1 = read, 0 = write.
- cmd_addr  in  MAX_ADDR_BITS-1  register address (low addr_bits-1 bits used).
- cmd_data  in  MAX_DATA_BITS  write data (low data_bits used; ignored for reads).
- cfg_addr_bits  in  5  address field width including R/W bit; sampled at accept.
- cfg_data_bits  in  5  data field width; sampled at accept.
- rsp_valid  out  1  one-cycle strobe; read data valid.
- rsp_data  out  MAX_DATA_BITS  read data, zero-extended.
- busy  out  1  high from accept until cmd_ready reasserts.
- sck  out  1  SPI clock, idles low.
- ss  out  1  slave select, active low.
- mosi  out  1  serial data out.
- miso  in  1  serial data in; may be z when the slave is not driving it (bench pulls it down).

Behaviour:
- Reset (asynchronous): state IDLE; cmd_ready=1, busy=0, sck=0, ss=1, mosi=0, rsp_valid=0, rsp_data=0, shift registers cleared.
- Field widths:
  - A = cfg_addr_bits clamped to [2, MAX_ADDR_BITS].
  - D = cfg_data_bits clamped to [1, MAX_DATA_BITS].
  - N = A + D.
- Transmit word, MSB first: {cmd_read, cmd_addr[A-2:0], cmd_data[D-1:0]} for writes. For reads the data field is all zeros.
- States:
  - IDLE: cmd_ready=1. On accept, latch the word, A, D, and cmd_read. Go to SHIFT_LO, with cmd_ready=0 and busy=1 from the next cycle.
  - SHIFT_LO (CLK_DIV cycles): ss=0, sck=0, mosi = current bit. Then go to SHIFT_HI.
  - SHIFT_HI (CLK_DIV cycles): sck=1. miso is sampled on the clk edge where sck goes 1. At the end of the phase:
    - If bits remain: set sck=0, advance mosi to the next bit, go to SHIFT_LO.
    - Otherwise: go to HOLD.
  - HOLD (CLK_DIV cycles): sck=0, ss=0, mosi holds the last bit. Then set ss=1 and go to GAP.
  - GAP (SS_GAP cycles): ss=1, mosi=0. Then go to IDLE; cmd_ready=1 and busy=0 in that same cycle.
- Frame timing, with the accept edge at cycle T:
  - ss falls at T+1.
  - Exactly N rising sck edges per frame; the first occurs at T+1+CLK_DIV.
  - ss rises at T+1+(2N+1)·CLK_DIV.
  - Next accept is possible no earlier than SS_GAP cycles after the ss rise.
- mosi changes only while sck=0 (at entry to a SHIFT_LO phase); it is never changed on the cycle sck rises.
- Read response:
  - rsp_data = the last D miso samples, MSB first, zero-extended.
  - rsp_valid pulses exactly 1 cycle, coincident with the ss rise.
  - rsp_data holds until the next read response.
  - Writes produce no rsp_valid.
- cmd_* and cfg_* are ignored while busy. Changing cfg mid-frame has no effect on the frame in flight.
- cmd_valid held continuously gives back-to-back frames, each separated by exactly SS_GAP cycles of ss high.
- Reset mid-frame: outputs return to reset values immediately (ss=1, sck=0). No rsp_valid is issued and the command is dropped.
- CLK_DIV=1: sck toggles every cycle and the timing above still holds.

Test Plan:
- Write: CLK_DIV=2, SS_GAP=4, A=8, D=8, write addr 0x12 data 0xA5 → mosi stream 0x12A5 (16 bits); ss low 66 cycles; 16 sck rises; slave register 0x12 = 0xA5; no rsp_valid.
- Read: preload slave storage[0x92]=0x5A, read addr 0x12, A=D=8 → first mosi bit 1; rsp_valid for 1 cycle at the ss rise with rsp_data=0x005A.
- Back-to-back: cmd_valid held for 3 writes → 3 frames, ss high exactly 4 cycles between frames; cmd_ready low throughout each frame.
- Width modes: A=16, D=16, write addr 0x0345 data 0xBEEF → 32 sck rises, mosi 0x0345BEEF. Then A=0, D=20 → clamped to A=2, D=16.
- Reset mid-frame: assert reset after 5 sck rises → same-cycle ss=1, sck=0, cmd_ready=1, no rsp_valid. A subsequent write completes normally.
- CLK_DIV=1 read → sck period 2 clk cycles; rsp_data matches the preloaded value.

Source files
------------

// File: rtl/spi_master_ctrl_if.sv
// Command/response bus of the SPI register master.
// master drives commands; slave is the controller itself.
interface spi_master_ctrl_if #(
    parameter int MAX_ADDR_BITS = 16,
    parameter int MAX_DATA_BITS = 16
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_read;
    logic [MAX_ADDR_BITS-2:0] cmd_addr;
    logic [MAX_DATA_BITS-1:0] cmd_data;
    logic [4:0]               cfg_addr_bits;
    logic [4:0]               cfg_data_bits;
    logic                     rsp_valid;
    logic [MAX_DATA_BITS-1:0] rsp_data;
    logic                     busy;

    modport master (
        output cmd_valid, cmd_read, cmd_addr, cmd_data,
        output cfg_addr_bits, cfg_data_bits,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_read, cmd_addr, cmd_data,
        input  cfg_addr_bits, cfg_data_bits,
        output cmd_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master turning register read/write commands
// into {R/W, addr, data} frames, MSB first.
module spi_master_ctrl #(
    parameter int MAX_ADDR_BITS = 16,
    parameter int MAX_DATA_BITS = 16,
    parameter int CLK_DIV       = 4,
    parameter int SS_GAP        = 4
) (
    input  logic              clk,
    input  logic              reset,
    spi_master_ctrl_if.slave  bus,
    output logic              sck,
    output logic              ss,
    output logic              mosi,
    input  logic              miso
);
    localparam int W    = MAX_ADDR_BITS + MAX_DATA_BITS;
    localparam int NW   = $clog2(W + 1);
    localparam int CMAX = (CLK_DIV > SS_GAP) ? CLK_DIV : SS_GAP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(SS_GAP - 1);
    localparam logic [NW-1:0] WN       = NW'(W);

    typedef enum logic [2:0] {
        IDLE, SHIFT_LO, SHIFT_HI, HOLD, GAP
    } state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [NW-1:0]            left_q, left_d;
    logic [NW-1:0]            dbits_q, dbits_d;
    logic [W-1:0]             tx_q, tx_d;
    logic [MAX_DATA_BITS-1:0] rx_q, rx_d;
    logic                     read_q, read_d;
    logic                     sck_d, ss_d, mosi_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [MAX_DATA_BITS-1:0] rsp_data_q, rsp_data_d;

    logic                     ready, accept;
    logic [NW-1:0]            a_w, d_w, n_w;
    logic [W-1:0]             amask, dmask, word, tx_new;

    // The last gap cycle already accepts, so back-to-back
    // frames see exactly SS_GAP cycles of ss high.
    assign ready = (state_q == IDLE) ||
                   (state_q == GAP && cnt_q == GAP_LAST);
    assign accept = bus.cmd_valid && ready;

    assign bus.cmd_ready = ready;
    assign bus.busy      = ~ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

    // Clamp field widths and build the left-aligned frame.
    always_comb begin
        a_w = NW'(bus.cfg_addr_bits);
        d_w = NW'(bus.cfg_data_bits);
        if (bus.cfg_addr_bits < 5'd2)
            a_w = NW'(2);
        else if (int'(bus.cfg_addr_bits) > MAX_ADDR_BITS)
            a_w = NW'(MAX_ADDR_BITS);
        if (bus.cfg_data_bits < 5'd1)
            d_w = NW'(1);
        else if (int'(bus.cfg_data_bits) > MAX_DATA_BITS)
            d_w = NW'(MAX_DATA_BITS);
        n_w    = a_w + d_w;
        amask  = (W'(1) << (a_w - NW'(1))) - W'(1);
        dmask  = (W'(1) << d_w) - W'(1);
        word   = (W'(bus.cmd_read) << (n_w - NW'(1)))
               | ((W'(bus.cmd_addr) & amask) << d_w)
               | (bus.cmd_read ? '0 : (W'(bus.cmd_data) & dmask));
        tx_new = word << (WN - n_w);
    end

    // Next-state, shift and pin logic of the frame sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        left_d      = left_q;
        dbits_d     = dbits_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        read_d      = read_q;
        sck_d       = sck;
        ss_d        = ss;
        mosi_d      = mosi;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        unique case (state_q)
            IDLE: begin
            end
            SHIFT_LO: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = SHIFT_HI;
                    cnt_d   = '0;
                    sck_d   = 1'b1;
                    rx_d    = {rx_q[MAX_DATA_BITS-2:0], miso};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SHIFT_HI: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    sck_d = 1'b0;
                    if (left_q > NW'(1)) begin
                        state_d = SHIFT_LO;
                        left_d  = left_q - NW'(1);
                        tx_d    = tx_q << 1;
                        mosi_d  = tx_q[W-2];
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    state_d     = GAP;
                    cnt_d       = '0;
                    ss_d        = 1'b1;
                    mosi_d      = 1'b0;
                    rsp_valid_d = read_q;
                    if (read_q)
                        rsp_data_d = rx_q &
                            ~({MAX_DATA_BITS{1'b1}} << dbits_q);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST)
                    state_d = IDLE;
                else
                    cnt_d = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d = SHIFT_LO;
            cnt_d   = '0;
            left_d  = n_w;
            dbits_d = d_w;
            tx_d    = tx_new;
            read_d  = bus.cmd_read;
            ss_d    = 1'b0;
            sck_d   = 1'b0;
            mosi_d  = tx_new[W-1];
        end
    end

    // State and registered pins; reset drops any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            left_q      <= '0;
            dbits_q     <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            read_q      <= 1'b0;
            sck         <= 1'b0;
            ss          <= 1'b1;
            mosi        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            left_q      <= left_d;
            dbits_q     <= dbits_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            read_q      <= read_d;
            sck         <= sck_d;
            ss          <= ss_d;
            mosi        <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: two instances
// (CLK_DIV 2 and 1) sharing one bus monitor and slave model.
module tb_spi_master_ctrl;
    localparam int MA = 16;
    localparam int MD = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sel = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_read = 1'b0;
    logic [MA-2:0] cmd_addr = '0;
    logic [MD-1:0] cmd_data = '0;
    logic [4:0]    cfg_a = 5'd8;
    logic [4:0]    cfg_d = 5'd8;
    logic          miso_r = 1'b0;
    logic          sck0, ss0, mosi0, sck1, ss1, mosi1;

    always #5 clk = ~clk;

    spi_master_ctrl_if #(.MAX_ADDR_BITS(MA), .MAX_DATA_BITS(MD)) bif0 ();
    spi_master_ctrl_if #(.MAX_ADDR_BITS(MA), .MAX_DATA_BITS(MD)) bif1 ();

    assign bif0.cmd_valid     = cmd_valid & ~sel;
    assign bif0.cmd_read      = cmd_read;
    assign bif0.cmd_addr      = cmd_addr;
    assign bif0.cmd_data      = cmd_data;
    assign bif0.cfg_addr_bits = cfg_a;
    assign bif0.cfg_data_bits = cfg_d;
    assign bif1.cmd_valid     = cmd_valid & sel;
    assign bif1.cmd_read      = cmd_read;
    assign bif1.cmd_addr      = cmd_addr;
    assign bif1.cmd_data      = cmd_data;
    assign bif1.cfg_addr_bits = cfg_a;
    assign bif1.cfg_data_bits = cfg_d;

    spi_master_ctrl #(
        .MAX_ADDR_BITS(MA), .MAX_DATA_BITS(MD),
        .CLK_DIV(2), .SS_GAP(4)
    ) u_dut0 (
        .clk(clk), .reset(reset), .bus(bif0),
        .sck(sck0), .ss(ss0), .mosi(mosi0), .miso(miso_r)
    );

    spi_master_ctrl #(
        .MAX_ADDR_BITS(MA), .MAX_DATA_BITS(MD),
        .CLK_DIV(1), .SS_GAP(4)
    ) u_dut1 (
        .clk(clk), .reset(reset), .bus(bif1),
        .sck(sck1), .ss(ss1), .mosi(mosi1), .miso(miso_r)
    );

    logic          sck_m, ss_m, mosi_m, ready_m, busy_m, rspv_m;
    logic [MD-1:0] rspd_m;
    assign sck_m   = sel ? sck1 : sck0;
    assign ss_m    = sel ? ss1 : ss0;
    assign mosi_m  = sel ? mosi1 : mosi0;
    assign ready_m = sel ? bif1.cmd_ready : bif0.cmd_ready;
    assign busy_m  = sel ? bif1.busy : bif0.busy;
    assign rspv_m  = sel ? bif1.rsp_valid : bif0.rsp_valid;
    assign rspd_m  = sel ? bif1.rsp_data : bif0.rsp_data;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0, rises = 0, frames = 0, ss_low = 0;
    int          last_len = 0, gap_cnt = 0, rsp_cnt = 0;
    int          rsp_coinc = 0, ready_viol = 0, mosi_viol = 0;
    int          t_fall = 0, t_r1 = 0, t_r2 = 0, t_acc = 0;
    int          gaps[$];
    logic [63:0] shreg = '0;
    logic [7:0]  idx = '0;
    logic [7:0]  storage [0:255];
    logic        sck_p = 1'b0, ss_p = 1'b1, mosi_p = 1'b0;

    // Bus monitor plus 8+8 register slave; storage is indexed by the
    // whole first byte, so a read of 0x12 addresses entry 0x92.
    always @(negedge clk) begin
        cyc++;
        if (!ss_m && ss_p) begin
            rises = 0; shreg = '0; idx = '0; ss_low = 0;
            t_fall = cyc;
            gaps.push_back(gap_cnt);
        end
        if (!ss_m) begin
            ss_low++;
            if (ready_m) ready_viol++;
        end
        if (ss_m && !ss_p) begin
            last_len = ss_low;
            frames++;
            gap_cnt = 0;
            if (rises == 16 && !shreg[15])
                storage[shreg[15:8]] = shreg[7:0];
        end
        if (ss_m) gap_cnt++;
        if (sck_m && !sck_p) begin
            rises++;
            shreg = {shreg[62:0], mosi_m};
            if (rises == 1) t_r1 = cyc;
            if (rises == 2) t_r2 = cyc;
            if (rises == 8) idx = shreg[7:0];
        end
        if (sck_m && mosi_m !== mosi_p) mosi_viol++;
        if (rspv_m) begin
            rsp_cnt++;
            if (ss_m && !ss_p) rsp_coinc++;
        end
        if (!ss_m && rises >= 8 && rises < 16 && idx[7])
            miso_r = storage[idx][15-rises];
        else
            miso_r = 1'b0;
        sck_p = sck_m; ss_p = ss_m; mosi_p = mosi_m;
    end

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 2000 && !ready_m; i++) tick();
        chk("ready_timeout", 64'(ready_m), 64'd1);
    endtask

    task automatic wait_frames(input int n);
        int target;
        target = frames + n;
        for (int i = 0; i < 4000 && frames < target; i++) tick();
        chk("frame_timeout", 64'(frames >= target), 64'd1);
    endtask

    task automatic send(input logic rd, input logic [14:0] a,
                        input logic [15:0] d,
                        input logic [4:0] ab, input logic [4:0] db);
        cmd_read = rd; cmd_addr = a; cmd_data = d;
        cfg_a = ab; cfg_d = db; cmd_valid = 1'b1;
        wait_ready();
        t_acc = cyc;
        tick();
        cmd_valid = 1'b0;
        chk("busy_after_accept", {62'd0, ready_m, busy_m}, 64'd1);
    endtask

    int r0;

    initial begin
        for (int i = 0; i < 256; i++) storage[i] = 8'h00;
        storage[8'h92] = 8'h5A;
        storage[8'h85] = 8'hC3;
        repeat (3) tick();
        chk("rst_ready", 64'(ready_m), 64'd1);
        chk("rst_busy", 64'(busy_m), 64'd0);
        chk("rst_pins", {61'd0, sck_m, ss_m, mosi_m}, 64'b010);
        chk("rst_rsp", {47'd0, rspv_m, rspd_m}, 64'd0);
        reset = 1'b0;
        repeat (2) tick();

        send(1'b0, 15'h12, 16'h00A5, 5'd8, 5'd8);
        wait_frames(1);
        chk("wr_word", shreg, 64'h12A5);
        chk("wr_rises", 64'(rises), 64'd16);
        chk("wr_ss_low", 64'(last_len), 64'd66);
        chk("wr_ss_fall", 64'(t_fall - t_acc), 64'd1);
        chk("wr_first_rise", 64'(t_r1 - t_fall), 64'd2);
        chk("wr_slave_reg", 64'(storage[8'h12]), 64'hA5);
        chk("wr_no_rsp", 64'(rsp_cnt), 64'd0);

        send(1'b1, 15'h12, 16'hFFFF, 5'd8, 5'd8);
        wait_frames(1);
        tick();
        chk("rd_word", shreg, 64'h9200);
        chk("rd_rsp_cnt", 64'(rsp_cnt), 64'd1);
        chk("rd_rsp_coinc", 64'(rsp_coinc), 64'd1);
        chk("rd_rsp_data", 64'(rspd_m), 64'h005A);

        r0 = frames;
        gaps.delete();
        cmd_read = 1'b0; cfg_a = 5'd8; cfg_d = 5'd8;
        cmd_addr = 15'h01; cmd_data = 16'h11; cmd_valid = 1'b1;
        wait_ready(); tick();
        cmd_addr = 15'h02; cmd_data = 16'h22;
        wait_ready(); tick();
        cmd_addr = 15'h03; cmd_data = 16'h33;
        wait_ready(); tick();
        cmd_valid = 1'b0;
        wait_frames(3 - (frames - r0));
        chk("b2b_frames", 64'(frames - r0), 64'd3);
        chk("b2b_gap1", 64'(gaps[1]), 64'd4);
        chk("b2b_gap2", 64'(gaps[2]), 64'd4);
        chk("b2b_regs", {40'd0, storage[8'h01], storage[8'h02],
                         storage[8'h03]}, 64'h112233);
        chk("b2b_ready_low", 64'(ready_viol), 64'd0);
        chk("rsp_hold", 64'(rspd_m), 64'h005A);

        send(1'b0, 15'h0345, 16'hBEEF, 5'd16, 5'd16);
        cfg_a = 5'd8; cfg_d = 5'd8; cmd_data = 16'h0000;
        wait_frames(1);
        chk("w32_rises", 64'(rises), 64'd32);
        chk("w32_word", shreg, 64'h0345BEEF);
        chk("w32_ss_low", 64'(last_len), 64'd130);

        send(1'b0, 15'h7FFF, 16'h1234, 5'd0, 5'd20);
        wait_frames(1);
        chk("clamp_rises", 64'(rises), 64'd18);
        chk("clamp_word", shreg, 64'h11234);
        chk("clamp_ss_low", 64'(last_len), 64'd74);

        r0 = rsp_cnt;
        send(1'b1, 15'h12, 16'h0000, 5'd8, 5'd8);
        for (int i = 0; i < 200 && rises < 5; i++) tick();
        chk("mid_rises", 64'(rises), 64'd5);
        reset = 1'b1;
        #1;
        chk("mid_rst_pins", {62'd0, ss_m, sck_m}, 64'b10);
        chk("mid_rst_ready", 64'(ready_m), 64'd1);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("mid_no_rsp", 64'(rsp_cnt - r0), 64'd0);
        chk("mid_rsp_data", 64'(rspd_m), 64'd0);
        send(1'b0, 15'h20, 16'h0077, 5'd8, 5'd8);
        wait_frames(1);
        chk("post_rst_word", shreg, 64'h2077);
        chk("post_rst_reg", 64'(storage[8'h20]), 64'h77);

        sel = 1'b1;
        repeat (3) tick();
        r0 = rsp_cnt;
        send(1'b1, 15'h05, 16'h0000, 5'd8, 5'd8);
        wait_frames(1);
        tick();
        chk("d1_word", shreg, 64'h8500);
        chk("d1_ss_low", 64'(last_len), 64'd33);
        chk("d1_first_rise", 64'(t_r1 - t_fall), 64'd1);
        chk("d1_sck_period", 64'(t_r2 - t_r1), 64'd2);
        chk("d1_rsp_cnt", 64'(rsp_cnt - r0), 64'd1);
        chk("d1_rsp_data", 64'(rspd_m), 64'h00C3);
        chk("mosi_stable", 64'(mosi_viol), 64'd0);
        chk("ready_in_frame", 64'(ready_viol), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
